// File: rtl/sw_bridge_pkg.sv
// rtl/sw_bridge_pkg.sv - shared states, frame constants and helpers for the SW UART bridge
//
// Purpose: FSM state encoding, RX header byte, result status codes, result
// frame length and the bases-to-packed-bytes helper.
// Ports: none (package).
package sw_bridge_pkg;

  typedef enum logic [2:0] {
    S_QUERY_RX,
    S_READ,
    S_DISPATCH,
    S_WAIT_CORE,
    S_QUERY_TX,
    S_SEND
  } state_t;

  localparam logic [7:0] HDR_BYTE   = 8'h53;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_HDR = 8'hE0;
  localparam logic [7:0] ST_BAD_LEN = 8'hE1;
  localparam int         RESULT_BYTES = 5;

  // Bytes needed to carry n 2-bit bases: ceil(n/4).
  function automatic logic [7:0] packed_bytes(input logic [7:0] n);
    logic [8:0] t;
    t = {1'b0, n} + 9'd3;
    return {1'b0, t[8:2]};
  endfunction

endpackage

// File: rtl/sw_seq_unpacker.sv
// rtl/sw_seq_unpacker.sv - writes one packed byte (4 bases) into a sequence register
//
// Purpose: holds a 2-bit-per-base sequence; each write stores bases
// 4*wr_idx .. 4*wr_idx+3 from wr_data (base 4k in bits [1:0]).
// Bases at or beyond len are forced to 0 so padding bits never leak.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         zero the whole register (new frame header)
//   wr_en         write strobe
//   wr_idx        packed byte index within the sequence
//   wr_data       packed byte
//   len           valid sequence length in bases
//   seq           packed sequence, base i at [2i+1:2i]
module sw_seq_unpacker #(
  parameter int MAX_LEN = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [7:0]             wr_idx,
  input  logic [7:0]             wr_data,
  input  logic [7:0]             len,
  output logic [2*MAX_LEN-1:0]   seq
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      seq <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (wr_idx == 8'(i / 4)) begin
          seq[2*i +: 2] <= (8'(i) < len) ? wr_data[2*(i%4) +: 2] : 2'b00;
        end
      end
    end
  end

endmodule

// File: rtl/sw_avm_uart_bridge.sv
// rtl/sw_avm_uart_bridge.sv - Avalon-MM UART poller feeding a Smith-Waterman core
//
// Purpose: polls the UART status register, collects one length-prefixed
// 2-bit-packed frame, hands it to the core, then returns a 5-byte result
// (or an error frame) through the UART TX register.
// Ports:
//   avm_clk, avm_rst           clock, synchronous active-high reset
//   avm_*                      Avalon-MM master to the UART
//   core_i_valid/core_o_ready  job handshake; core_seq_*/core_*_len job payload
//   core_o_valid/core_i_ready  result handshake; core_score/column/row result
//   busy                       frame in progress (header accepted .. last TX byte)
//   err_count                  saturating count of error frames
module sw_avm_uart_bridge
  import sw_bridge_pkg::*;
#(
  parameter int REF_MAX_LENGTH  = 128,
  parameter int READ_MAX_LENGTH = 128,
  parameter int SCORE_W         = 10,
  parameter int RX_BASE         = 0,
  parameter int TX_BASE         = 4,
  parameter int STATUS_BASE     = 8,
  parameter int TX_OK_BIT       = 6,
  parameter int RX_OK_BIT       = 7
) (
  input  logic                           avm_clk,
  input  logic                           avm_rst,
  output logic [4:0]                     avm_address,
  output logic                           avm_read,
  input  logic [31:0]                    avm_readdata,
  output logic                           avm_write,
  output logic [31:0]                    avm_writedata,
  input  logic                           avm_waitrequest,
  output logic                           core_i_valid,
  input  logic                           core_o_ready,
  output logic [2*REF_MAX_LENGTH-1:0]    core_seq_ref,
  output logic [2*READ_MAX_LENGTH-1:0]   core_seq_read,
  output logic [7:0]                     core_ref_len,
  output logic [7:0]                     core_read_len,
  input  logic                           core_o_valid,
  output logic                           core_i_ready,
  input  logic [SCORE_W-1:0]             core_score,
  input  logic [7:0]                     core_column,
  input  logic [7:0]                     core_row,
  output logic                           busy,
  output logic [7:0]                     err_count
);

  localparam logic [4:0] A_RX     = 5'(RX_BASE);
  localparam logic [4:0] A_TX     = 5'(TX_BASE);
  localparam logic [4:0] A_STATUS = 5'(STATUS_BASE);

  state_t     state;
  logic [7:0] pos;       // frame byte position: 0 hdr, 1 L, 2 R, 3.. payload
  logic [2:0] tx_idx;
  logic [7:0] tx_frame [RESULT_BYTES];

  logic [7:0]  rx_byte, ref_nb, read_nb, pay_idx, read_idx;
  logic        rd_done, hdr_ok, bad_len, err_hit, ref_wr, read_wr, last;
  logic [7:0]  err_code;
  logic [15:0] score_ext;
  logic        unused_bits;

  assign rx_byte     = avm_readdata[7:0];
  assign unused_bits = ^avm_readdata[31:8];
  assign score_ext   = 16'($signed(core_score));

  assign ref_nb   = packed_bytes(core_ref_len);
  assign read_nb  = packed_bytes(core_read_len);
  assign pay_idx  = pos - 8'd3;
  assign read_idx = pay_idx - ref_nb;

  assign rd_done = (state == S_READ) && !avm_waitrequest;
  assign hdr_ok  = rd_done && (pos == 8'd0) && (rx_byte == HDR_BYTE);
  // At pos 2 the ref length is already registered; the read length is the live byte.
  assign bad_len = (core_ref_len == 8'd0) || (core_ref_len > 8'(REF_MAX_LENGTH)) ||
                   (rx_byte == 8'd0) || (rx_byte > 8'(READ_MAX_LENGTH));
  assign err_hit = rd_done && (((pos == 8'd0) && (rx_byte != HDR_BYTE)) ||
                               ((pos == 8'd2) && bad_len));
  assign err_code = (pos == 8'd0) ? ST_BAD_HDR : ST_BAD_LEN;

  assign ref_wr  = rd_done && (pos >= 8'd3) && (pay_idx <  ref_nb);
  assign read_wr = rd_done && (pos >= 8'd3) && (pay_idx >= ref_nb);
  assign last    = (pay_idx == ref_nb + read_nb - 8'd1);

  sw_seq_unpacker #(.MAX_LEN(REF_MAX_LENGTH)) u_ref (
    .clk(avm_clk), .rst(avm_rst), .clear(hdr_ok), .wr_en(ref_wr),
    .wr_idx(pay_idx), .wr_data(rx_byte), .len(core_ref_len), .seq(core_seq_ref)
  );

  sw_seq_unpacker #(.MAX_LEN(READ_MAX_LENGTH)) u_read (
    .clk(avm_clk), .rst(avm_rst), .clear(hdr_ok), .wr_en(read_wr),
    .wr_idx(read_idx), .wr_data(rx_byte), .len(core_read_len), .seq(core_seq_read)
  );

  // Avalon outputs only change on a completed transfer (waitrequest low) while
  // a transfer is pending, so they hold exactly through any stall.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state         <= S_QUERY_RX;
      avm_read      <= 1'b1;
      avm_address   <= A_STATUS;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      core_i_valid  <= 1'b0;
      core_i_ready  <= 1'b0;
      core_ref_len  <= '0;
      core_read_len <= '0;
      busy          <= 1'b0;
      err_count     <= '0;
      pos           <= '0;
      tx_idx        <= '0;
      for (int i = 0; i < RESULT_BYTES; i++) tx_frame[i] <= '0;
    end else begin
      case (state)
        S_QUERY_RX: if (!avm_waitrequest && avm_readdata[RX_OK_BIT]) begin
          avm_address <= A_RX;
          state       <= S_READ;
        end
        S_READ: if (!avm_waitrequest) begin
          avm_address <= A_STATUS;
          state       <= S_QUERY_RX;
          if (err_hit) begin
            // Error frame goes out immediately; remaining RX bytes are left to the host.
            tx_frame[0] <= err_code;
            for (int i = 1; i < RESULT_BYTES; i++) tx_frame[i] <= 8'h00;
            tx_idx <= '0;
            pos    <= '0;
            busy   <= 1'b1;
            state  <= S_QUERY_TX;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else if (pos == 8'd0) begin
            busy <= 1'b1;
            pos  <= 8'd1;
          end else if (pos == 8'd1) begin
            core_ref_len <= rx_byte;
            pos          <= 8'd2;
          end else if (pos == 8'd2) begin
            core_read_len <= rx_byte;
            pos           <= 8'd3;
          end else if (last) begin
            avm_read     <= 1'b0;
            core_i_valid <= 1'b1;
            state        <= S_DISPATCH;
          end else begin
            pos <= pos + 8'd1;
          end
        end
        S_DISPATCH: if (core_o_ready) begin
          core_i_valid <= 1'b0;
          core_i_ready <= 1'b1;
          state        <= S_WAIT_CORE;
        end
        S_WAIT_CORE: if (core_o_valid) begin
          core_i_ready <= 1'b0;
          tx_frame     <= '{ST_OK, score_ext[15:8], score_ext[7:0], core_column, core_row};
          tx_idx       <= '0;
          avm_read     <= 1'b1;
          avm_address  <= A_STATUS;
          state        <= S_QUERY_TX;
        end
        S_QUERY_TX: if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
          avm_read      <= 1'b0;
          avm_write     <= 1'b1;
          avm_address   <= A_TX;
          avm_writedata <= {24'h0, tx_frame[tx_idx]};
          state         <= S_SEND;
        end
        S_SEND: if (!avm_waitrequest) begin
          avm_write     <= 1'b0;
          avm_writedata <= '0;
          avm_read      <= 1'b1;
          avm_address   <= A_STATUS;
          if (tx_idx == 3'(RESULT_BYTES - 1)) begin
            busy  <= 1'b0;
            pos   <= '0;
            state <= S_QUERY_RX;
          end else begin
            tx_idx <= tx_idx + 3'd1;
            state  <= S_QUERY_TX;
          end
        end
        default: state <= S_QUERY_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_avm_uart_bridge.sv
// tb/tb_sw_avm_uart_bridge.sv - directed scoreboard bench for sw_avm_uart_bridge
module tb_sw_avm_uart_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   avm_address;
  logic         avm_read, avm_write, avm_waitrequest;
  logic [31:0]  avm_readdata, avm_writedata;
  logic         core_i_valid, core_o_ready, core_o_valid, core_i_ready;
  logic [255:0] core_seq_ref, core_seq_read;
  logic [7:0]   core_ref_len, core_read_len, core_column, core_row, err_count;
  logic [9:0]   core_score;
  logic         busy;

  int checks = 0;
  int failures = 0;

  byte unsigned rx_q[$];
  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  int  rx_rd = 0, got_rd = 0;
  int  wait_n = 0, wait_cnt = 0;
  int  stable_err = 0, wd_err = 0, civ_count = 0;
  bit  stalled = 1'b0, tx_ok = 1'b1;
  logic [38:0] snap;

  sw_avm_uart_bridge dut (
    .avm_clk(clk), .avm_rst(rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .core_i_valid(core_i_valid), .core_o_ready(core_o_ready),
    .core_seq_ref(core_seq_ref), .core_seq_read(core_seq_read),
    .core_ref_len(core_ref_len), .core_read_len(core_read_len),
    .core_o_valid(core_o_valid), .core_i_ready(core_i_ready),
    .core_score(core_score), .core_column(core_column), .core_row(core_row),
    .busy(busy), .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // UART slave model: completion bookkeeping on the rising edge, waitrequest
  // and readdata driven on the falling edge.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (core_i_valid) civ_count++;
      if (rst) begin
        wait_cnt = 0;
        stalled  = 1'b0;
      end else if ((avm_read || avm_write) && !avm_waitrequest) begin
        if (avm_read && avm_address == 5'd0 && rx_rd < rx_q.size()) rx_rd++;
        if (avm_write && avm_address == 5'd4) begin
          got_q.push_back(avm_writedata[7:0]);
          if (avm_writedata[31:8] != 24'h0) wd_err++;
        end
        wait_cnt = 0;
        stalled  = 1'b0;
      end else if (avm_read || avm_write) begin
        stalled = 1'b1;
        snap    = {avm_address, avm_read, avm_write, avm_writedata};
      end else begin
        stalled = 1'b0;
      end
    end else begin
      if (stalled && ({avm_address, avm_read, avm_write, avm_writedata} !== snap)) stable_err++;
      if ((avm_read || avm_write) && wait_cnt < wait_n) begin
        avm_waitrequest = 1'b1;
        wait_cnt++;
      end else begin
        avm_waitrequest = 1'b0;
      end
      tx_ok = ($urandom_range(0, 3) != 0);
      if (avm_address == 5'd8)
        avm_readdata = {24'hA5A5A5, (rx_rd < rx_q.size()), tx_ok, 6'h0};
      else if (avm_address == 5'd0 && rx_rd < rx_q.size())
        avm_readdata = {24'h5A5A5A, rx_q[rx_rd]};
      else
        avm_readdata = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_rx(input byte unsigned b);
    rx_q.push_back(b);
  endtask

  task automatic push_exp(input byte unsigned a, b, c, d, e);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
    exp_q.push_back(d); exp_q.push_back(e);
  endtask

  task automatic send_basic();
    push_rx(8'h53); push_rx(8'h05); push_rx(8'h03);
    push_rx(8'hE4); push_rx(8'h01); push_rx(8'h24);
  endtask

  function automatic byte unsigned max_byte(input int k);
    if (k == 0) return 8'h53;
    if (k < 3) return 8'd128;
    if (k < 35) return 8'((k - 3) * 37 + 11);
    return 8'((k - 35) * 91 + 5);
  endfunction

  task automatic serve_core(input string tag, input logic [255:0] eref, eread,
                            input logic [7:0] l, r, input int stall,
                            input logic [9:0] sc, input logic [7:0] col, row);
    int n;
    bit held;
    n = 0;
    while (!core_i_valid && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_dispatch"}, 256'(core_i_valid), 256'(1));
    chk({tag, "_seq_ref"}, core_seq_ref, eref);
    chk({tag, "_seq_read"}, core_seq_read, eread);
    chk({tag, "_lens"}, 256'({core_ref_len, core_read_len}), 256'({l, r}));
    chk({tag, "_busy"}, 256'(busy), 256'(1));
    held = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!core_i_valid || core_seq_ref !== eref || core_seq_read !== eread) held = 1'b0;
    end
    if (stall > 0) chk({tag, "_hold"}, 256'(held), 256'(1));
    core_o_ready = 1'b1;
    @(negedge clk);
    core_o_ready = 1'b0;
    chk({tag, "_handoff"}, 256'({core_i_valid, core_i_ready, avm_read, avm_write}), 256'(4'b0100));
    core_score = sc; core_column = col; core_row = row; core_o_valid = 1'b1;
    @(negedge clk);
    core_o_valid = 1'b0;
    chk({tag, "_latched"}, 256'(core_i_ready), 256'(0));
  endtask

  task automatic expect_tx(input string tag);
    int n;
    logic [7:0] e, g;
    n = 0;
    while (got_q.size() < got_rd + 5 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_tx_count"}, 256'(got_q.size() >= got_rd + 5), 256'(1));
    for (int i = 0; i < 5; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      g = (got_rd < got_q.size()) ? got_q[got_rd] : 8'hxx;
      got_rd++;
      chk($sformatf("%s_tx%0d", tag, i), 256'(g), 256'(e));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_avm"}, 256'({avm_read, avm_address, avm_write, avm_writedata}),
        256'({1'b1, 5'd8, 1'b0, 32'd0}));
    chk({tag, "_core"}, 256'({core_i_valid, core_i_ready, busy, err_count}), 256'(0));
    chk({tag, "_seq"}, core_seq_ref | core_seq_read, 256'(0));
    chk({tag, "_len"}, 256'({core_ref_len, core_read_len}), 256'(0));
  endtask

  initial begin
    logic [255:0] eref, eread;
    int civ0, n0, n;
    rst = 1'b1;
    core_o_ready = 1'b0; core_o_valid = 1'b0;
    core_score = '0; core_column = '0; core_row = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Basic frame, negative score.
    send_basic();
    push_exp(8'h00, 8'hFF, 8'hFD, 8'h05, 8'h03);
    serve_core("t1", 256'h1E4, 256'h24, 8'd5, 8'd3, 0, 10'h3FD, 8'd5, 8'd3);
    expect_tx("t1");
    chk("t1_busy_done", 256'(busy), 256'(0));

    // Same frame with 3 stall cycles on every transfer.
    wait_n = 3;
    send_basic();
    push_exp(8'h00, 8'hFF, 8'hFD, 8'h05, 8'h03);
    serve_core("t2", 256'h1E4, 256'h24, 8'd5, 8'd3, 0, 10'h3FD, 8'd5, 8'd3);
    expect_tx("t2");
    chk("t2_stable", 256'(stable_err), 256'(0));
    wait_n = 0;

    // Bad header, then a good frame with padding bits that must be masked.
    push_rx(8'h41);
    push_exp(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_tx("t3_err");
    chk("t3_err_count", 256'(err_count), 256'(1));
    push_rx(8'h53); push_rx(8'h04); push_rx(8'h01); push_rx(8'h1B); push_rx(8'hFE);
    push_exp(8'h00, 8'h00, 8'h05, 8'h10, 8'h01);
    serve_core("t3", 256'h1B, 256'h2, 8'd4, 8'd1, 0, 10'h005, 8'h10, 8'h01);
    expect_tx("t3");

    // Bad lengths: L=0, then L=REF_MAX+1.
    civ0 = civ_count;
    push_rx(8'h53); push_rx(8'h00); push_rx(8'h03);
    push_exp(8'hE1, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_tx("t4a");
    chk("t4a_err_count", 256'(err_count), 256'(2));
    push_rx(8'h53); push_rx(8'd129); push_rx(8'h01);
    push_exp(8'hE1, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_tx("t4b");
    chk("t4b_err_count", 256'(err_count), 256'(3));
    chk("t4_no_dispatch", 256'(civ_count - civ0), 256'(0));

    // Max-length frame with core backpressure and a positive score.
    wait_n = 1;
    eref = '0; eread = '0;
    for (int k = 0; k < 67; k++) push_rx(max_byte(k));
    for (int j = 0; j < 32; j++) begin
      eref[8*j +: 8]  = max_byte(3 + j);
      eread[8*j +: 8] = max_byte(35 + j);
    end
    push_exp(8'h00, 8'h00, 8'hC8, 8'h80, 8'h7F);
    serve_core("t5", eref, eread, 8'd128, 8'd128, 10, 10'd200, 8'h80, 8'h7F);
    expect_tx("t5");
    wait_n = 0;
    chk("t5_wdata_upper", 256'(wd_err), 256'(0));

    // Reset after byte 10 of a max frame.
    for (int k = 0; k < 10; k++) push_rx(max_byte(k));
    n = 0;
    while (rx_rd < rx_q.size() && n < 2000) begin @(negedge clk); n++; end
    chk("t6_rx_drained", 256'(rx_rd == rx_q.size()), 256'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("t6_reset");
    rst = 1'b0;
    n0 = got_q.size();
    repeat (30) @(negedge clk);
    chk("t6_no_tx", 256'(got_q.size()), 256'(n0));
    send_basic();
    push_exp(8'h00, 8'hFF, 8'hFD, 8'h05, 8'h03);
    serve_core("t6", 256'h1E4, 256'h24, 8'd5, 8'd3, 0, 10'h3FD, 8'd5, 8'd3);
    expect_tx("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
